// File: rtl/fb_scan_arbiter.sv
// Frame-buffer arbiter: VGA scan-out reads (fixed priority) vs edge-detector writes.
// Define FB_TEAR_LOCK_EN to confine writes to vertical blanking.
module fb_scan_arbiter #(
    parameter int IMG_W  = 200,
    parameter int IMG_H  = 200,
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        counter_x,
    input  logic [9:0]        counter_y,
    input  logic              in_display_area,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid
);

    localparam logic [1:0] S_VBLANK = 2'd0;
    localparam logic [1:0] S_LINE   = 2'd1;
    localparam logic [1:0] S_HGAP   = 2'd2;

    localparam int AW1 = ADDR_W + 1;

    localparam logic [9:0]        X_LIM    = 10'(IMG_W);
    localparam logic [9:0]        Y_LIM    = 10'(IMG_H);
    localparam logic [9:0]        X_LAST   = 10'(IMG_W - 1);
    localparam logic [9:0]        Y_LAST   = 10'(IMG_H - 1);
    localparam logic [ADDR_W:0]   A_LIM    = AW1'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_nx;
    logic [ADDR_W-1:0] next_row;
    logic [9:0]        y_prev;

    logic win;
    logic scan;
    logic slot;
    logic wr_go;
    logic wr_in_rng;
    logic at_row_end;
    logic frame_end;
    logic y_wrap;
    logic rd_q;

    assign win = in_display_area
               & (counter_x < X_LIM)
               & (counter_y < Y_LIM);

    // After a mid-frame reset the scan waits for line 0 of the next frame.
    assign scan = win
                & ((state != S_VBLANK) | (counter_y == '0));

    assign wr_in_rng  = {1'b0, wr_addr} < A_LIM;
    assign at_row_end = counter_x == X_LAST;
    assign frame_end  = ~scan
                      & (state != S_VBLANK)
                      & (counter_y >= Y_LIM);
    assign y_wrap     = ~win
                      & (counter_y == '0)
                      & (y_prev != '0);

    assign next_row = (counter_y == Y_LAST)
                    ? '0
                    : row_base + ROW_STEP;

`ifdef FB_TEAR_LOCK_EN
    assign slot = ~scan & (state == S_VBLANK);
`else
    assign slot = ~scan;
`endif

    // While wr_ack is high the request on the bus is the one just served.
    assign wr_go = wr_req & slot & ~wr_ack;

    always_comb begin
        state_nx    = state;
        row_base_nx = row_base;
        unique case (1'b1)
            y_wrap: begin
                state_nx    = S_VBLANK;
                row_base_nx = '0;
            end
            scan & at_row_end: begin
                state_nx    = S_HGAP;
                row_base_nx = next_row;
            end
            scan & ~at_row_end: begin
                state_nx = S_LINE;
            end
            frame_end: begin
                state_nx    = S_VBLANK;
                row_base_nx = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_VBLANK;
            row_base  <= '0;
            y_prev    <= '0;
            wr_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= 1'b0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            row_base <= row_base_nx;
            y_prev   <= counter_y;
            wr_ack   <= wr_go;

            unique case (1'b1)
                scan: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= row_base + ADDR_W'(counter_x);
                end
                wr_go: begin
                    // Out-of-range writes are acked but never reach the RAM.
                    mem_en    <= wr_in_rng;
                    mem_we    <= wr_in_rng;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase

            rd_q      <= mem_en & ~mem_we;
            pix_valid <= rd_q;
            pix_out   <= rd_q ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter on a shrunken raster and image.
// Driver predicts from raster/handshake rules; a negedge monitor checks.
module tb_fb_scan_arbiter;

    localparam int IMG_W  = 20;
    localparam int IMG_H  = 10;
    localparam int ADDR_W = 16;
    localparam int PIX_W  = 1;
    localparam int H_TOT  = 32;
    localparam int H_DISP = 26;
    localparam int V_TOT  = 16;
    localparam int V_DISP = 13;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int FRAME  = H_TOT * V_TOT;

    typedef struct {
        int t;
        int a;
        int d;
    } rec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        counter_x;
    logic [9:0]        counter_y;
    logic              in_display_area;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;
    logic [PIX_W-1:0]  pix_out;
    logic              pix_valid;

    logic [PIX_W-1:0] ram [0:65535];
    logic [PIX_W-1:0] img [0:NPIX-1];

    rec_t rd_q[$];
    rec_t px_q[$];
    rec_t ak_q[$];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit rst_q  = 1'b0;
    int cx;
    int cy;
    bit scan_ok;
    bit vb;
    bit served;
    bit pend;
    bit stop_wr;

    always #5 clk = ~clk;

    fb_scan_arbiter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .PIX_W (PIX_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .counter_x      (counter_x),
        .counter_y      (counter_y),
        .in_display_area(in_display_area),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .pix_out        (pix_out),
        .pix_valid      (pix_valid)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        rst_q  <= reset;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d, want %0d",
                     nm, edge_n, act, exp);
        end
    endtask

    // One cycle: writer, raster, then the expected outcome of the sample.
    task automatic step(input bit rst, input bit quiet);
        int   s;
        int   a;
        bit   win;
        bit   scan;
        bit   open;
        bit   acc;
        bit   de;
        rec_t r;
        @(posedge clk);
        #1;
        if (!wr_req || pend) begin
            if (stop_wr || quiet || $urandom_range(0, 3) == 0) begin
                wr_req = 1'b0;
            end else begin
                wr_req = 1'b1;
                if ($urandom_range(0, 7) == 0)
                    a = NPIX + int'($urandom_range(0, 40));
                else
                    a = int'($urandom_range(0, NPIX - 1));
                wr_addr = ADDR_W'(a);
                wr_data = PIX_W'($urandom_range(0, 1));
            end
        end
        pend = wr_ack;

        if (cx == H_TOT - 1) begin
            cx = 0;
            cy = (cy == V_TOT - 1) ? 0 : cy + 1;
        end else begin
            cx++;
        end
        de = !quiet && cx < H_DISP && cy < V_DISP;
        counter_x       = 10'(cx);
        counter_y       = 10'(cy);
        in_display_area = de;
        reset           = rst;

        s   = edge_n + 1;
        win = de && cx < IMG_W && cy < IMG_H;
        if (rst) begin
            scan_ok = 1'b0;
            vb      = 1'b1;
            served  = 1'b0;
            while (px_q.size() > 0 && px_q[$].t >= s)
                px_q.delete(px_q.size() - 1);
        end else begin
            scan = win && (scan_ok || cy == 0);
`ifdef FB_TEAR_LOCK_EN
            open = vb;
`else
            open = 1'b1;
`endif
            acc = !scan && wr_req && !served && open;
            if (scan) begin
                scan_ok = 1'b1;
                vb      = 1'b0;
                a   = cy * IMG_W + cx;
                r.t = s;
                r.a = a;
                r.d = 0;
                rd_q.push_back(r);
                r.t = s + 2;
                r.d = int'(img[a]);
                px_q.push_back(r);
            end
            if (acc) begin
                a   = int'(wr_addr);
                r.t = s;
                r.a = a;
                r.d = int'(wr_data);
                ak_q.push_back(r);
                if (a < NPIX) img[a] = wr_data;
            end
            served = acc;
            if (!scan && cy >= IMG_H) vb = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (edge_n > 0) begin
            if (rst_q) begin
                chk("rst_wr_ack", int'(wr_ack), 0);
                chk("rst_mem_en", int'(mem_en), 0);
                chk("rst_mem_we", int'(mem_we), 0);
                chk("rst_mem_addr", int'(mem_addr), 0);
                chk("rst_mem_wdata", int'(mem_wdata), 0);
                chk("rst_pix_valid", int'(pix_valid), 0);
                chk("rst_pix_out", int'(pix_out), 0);
            end else begin
                if (px_q.size() > 0 && px_q[0].t == edge_n) begin
                    r = px_q.pop_front();
                    chk("pix_valid", int'(pix_valid), 1);
                    chk("pix_data", int'(pix_out), r.d);
                end else begin
                    chk("pix_valid_idle", int'(pix_valid), 0);
                    chk("pix_out_idle", int'(pix_out), 0);
                end
                if (ak_q.size() > 0 && ak_q[0].t == edge_n) begin
                    r = ak_q.pop_front();
                    chk("wr_ack", int'(wr_ack), 1);
                    if (r.a < NPIX) begin
                        chk("wr_mem_en", int'(mem_en), 1);
                        chk("wr_mem_we", int'(mem_we), 1);
                        chk("wr_mem_addr", int'(mem_addr), r.a);
                        chk("wr_mem_wdata", int'(mem_wdata), r.d);
                    end else begin
                        chk("oor_mem_en", int'(mem_en), 0);
                    end
                end else begin
                    chk("wr_ack_idle", int'(wr_ack), 0);
                    if (rd_q.size() > 0 && rd_q[0].t == edge_n) begin
                        r = rd_q.pop_front();
                        chk("rd_mem_en", int'(mem_en), 1);
                        chk("rd_mem_we", int'(mem_we), 0);
                        chk("rd_mem_addr", int'(mem_addr), r.a);
                    end else begin
                        chk("mem_en_idle", int'(mem_en), 0);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = PIX_W'(i & 1);
        for (int i = 0; i < NPIX; i++)  img[i] = PIX_W'(i & 1);
        scan_ok         = 1'b0;
        vb              = 1'b1;
        served          = 1'b0;
        pend            = 1'b0;
        stop_wr         = 1'b0;
        mem_rdata       = '0;
        cx              = 0;
        cy              = V_DISP;
        reset           = 1'b1;
        wr_req          = 1'b1;
        wr_addr         = ADDR_W'(7);
        wr_data         = 1'b0;
        counter_x       = 10'(cx);
        counter_y       = 10'(cy);
        in_display_area = 1'b0;

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 5 * FRAME; i++) step(1'b0, 1'b0);

        for (int i = 0; i < FRAME && !(cx == 4 && cy == 5); i++)
            step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 8 * FRAME; i++) step(1'b0, 1'b0);

        stop_wr = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        @(negedge clk);

        chk("pix_pending", px_q.size(), 0);
        chk("rd_pending", rd_q.size(), 0);
        chk("ack_pending", ak_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
